// File: rtl/rocket_motion.sv
// Rocket vertical motion for one Space Race player: Y register, frame-rate FSM, hit lockout,
// scoring and per-line window/row generation. Optional macro ROCKET_BLINK_EN blinks the rocket during HOLD.
module rocket_motion #(
    parameter logic [7:0] START_Y    = 8'd208,
    parameter int         ROCKET_H   = 16,
    parameter int         HIT_FRAMES = 64
) (
    input  logic       CLK_DRV,
    input  logic       RESET_N,
    input  logic       R_RESET,
    input  logic       V_WINDOW,
    input  logic [7:0] V,
    input  logic       UP_N,
    input  logic       DOWN_N,
    input  logic       HIT,
    input  logic       ATTRACT,
    output logic       ROCKET_VWIN,
    output logic [3:0] ROCKET_ROW,
    output logic       STOP,
    output logic       SCORE_PULSE,
    output logic [7:0] Y_POS
);

    // The hold counter always has at least three bits so bit 2 exists for the blink cadence.
    localparam int             CW        = (HIT_FRAMES > 8) ? $clog2(HIT_FRAMES) : 3;
    localparam logic [CW-1:0]  HOLD_LOAD = CW'(HIT_FRAMES - 1);
    localparam logic [8:0]     HEIGHT9   = 9'(ROCKET_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      y_q, y_d;
    logic [CW-1:0]   holdCnt_q, holdCnt_d;
    logic            hitLatch_q, hitLatch_d;
    logic            scorePulse_q, scorePulse_d;
    logic            stop_q, stop_d;
    logic            vwin_q, vwin_d;
    logic [3:0]      row_q, row_d;
    logic            rrPrev_q;

    logic            tick;
    logic            upAct;
    logic            downAct;
    logic [7:0]      lineDelta;
    logic            inWindow;

    assign tick    = R_RESET & ~rrPrev_q;
    assign upAct   = ~UP_N;
    assign downAct = ~DOWN_N;

    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            y_q          <= START_Y;
            holdCnt_q    <= '0;
            hitLatch_q   <= 1'b0;
            scorePulse_q <= 1'b0;
            stop_q       <= 1'b1;
            vwin_q       <= 1'b0;
            row_q        <= 4'd0;
            rrPrev_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            holdCnt_q    <= holdCnt_d;
            hitLatch_q   <= hitLatch_d;
            scorePulse_q <= scorePulse_d;
            stop_q       <= stop_d;
            vwin_q       <= vwin_d;
            row_q        <= row_d;
            rrPrev_q     <= R_RESET;
        end
    end

    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        holdCnt_d    = holdCnt_q;
        hitLatch_d   = hitLatch_q;
        scorePulse_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                y_d        = START_Y;
                hitLatch_d = 1'b0;
                if (tick) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // A hit arriving on the tick cycle is latched here and only acted on at the next tick.
                hitLatch_d = hitLatch_q | HIT;
                if (tick) begin
                    if (hitLatch_q) begin
                        y_d        = START_Y;
                        hitLatch_d = 1'b0;
                        holdCnt_d  = HOLD_LOAD;
                        state_d    = HOLD;
                    end else if (upAct && (y_q == 8'd0)) begin
                        y_d          = START_Y;
                        scorePulse_d = 1'b1;
                    end else if (upAct && !downAct) begin
                        y_d = y_q - 8'd1;
                    end else if (downAct && !upAct && (y_q != START_Y)) begin
                        y_d = y_q + 8'd1;
                    end
                end
            end
            HOLD: begin
                y_d        = START_Y;
                hitLatch_d = 1'b0;
                if (tick) begin
                    if (holdCnt_q == '0) begin
                        state_d = PLAY;
                    end else begin
                        holdCnt_d = holdCnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = START_Y;
            end
        endcase

        if (tick && ATTRACT) begin
            state_d      = IDLE;
            y_d          = START_Y;
            holdCnt_d    = '0;
            hitLatch_d   = 1'b0;
            scorePulse_d = 1'b0;
        end

        stop_d = (y_d == START_Y);
    end

    always_comb begin
        lineDelta = V - y_q;
        inWindow  = V_WINDOW && ({1'b0, lineDelta} < HEIGHT9);
`ifdef ROCKET_BLINK_EN
        if ((state_q == HOLD) && !holdCnt_q[2]) begin
            inWindow = 1'b0;
        end
`endif
        vwin_d = inWindow;
        row_d  = inWindow ? lineDelta[3:0] : 4'd0;
    end

    assign ROCKET_VWIN = vwin_q;
    assign ROCKET_ROW  = row_q;
    assign STOP        = stop_q;
    assign SCORE_PULSE = scorePulse_q;
    assign Y_POS       = y_q;

endmodule

// File: tb/tb_rocket_motion.sv
// Self-checking bench for rocket_motion: directed frame scenarios plus random frames against a
// frame-level reference model of the rocket's position, lockout and scoring.
module tb_rocket_motion;

    localparam int HIT_FRAMES = 64;
    localparam int HOME_Y     = 208;

    logic       CLK_DRV;
    logic       RESET_N;
    logic       R_RESET;
    logic       V_WINDOW;
    logic [7:0] V;
    logic       UP_N;
    logic       DOWN_N;
    logic       HIT;
    logic       ATTRACT;
    logic       ROCKET_VWIN;
    logic [3:0] ROCKET_ROW;
    logic       STOP;
    logic       SCORE_PULSE;
    logic [7:0] Y_POS;

    rocket_motion #(
        .START_Y   (8'd208),
        .ROCKET_H  (16),
        .HIT_FRAMES(HIT_FRAMES)
    ) dut (
        .CLK_DRV    (CLK_DRV),
        .RESET_N    (RESET_N),
        .R_RESET    (R_RESET),
        .V_WINDOW   (V_WINDOW),
        .V          (V),
        .UP_N       (UP_N),
        .DOWN_N     (DOWN_N),
        .HIT        (HIT),
        .ATTRACT    (ATTRACT),
        .ROCKET_VWIN(ROCKET_VWIN),
        .ROCKET_ROW (ROCKET_ROW),
        .STOP       (STOP),
        .SCORE_PULSE(SCORE_PULSE),
        .Y_POS      (Y_POS)
    );

    initial CLK_DRV = 1'b0;
    always #5 CLK_DRV = ~CLK_DRV;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: game mode (0 idle, 1 play, 2 locked out), position, frames of lockout left.
    int mMode;
    int mY;
    int mLock;
    bit mLatch;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    function automatic void modelReset();
        mMode  = 0;
        mY     = HOME_Y;
        mLock  = 0;
        mLatch = 1'b0;
    endfunction

    function automatic bit modelTick(input bit up, input bit dn, input bit attract, input bit hitNow);
        bit score = 1'b0;
        if (attract) begin
            modelReset();
            return 1'b0;
        end
        case (mMode)
            0: mMode = 1;
            1: begin
                if (mLatch) begin
                    mY     = HOME_Y;
                    mLatch = 1'b0;
                    mMode  = 2;
                    mLock  = HIT_FRAMES;
                end else if (up && mY == 0) begin
                    mY    = HOME_Y;
                    score = 1'b1;
                end else if (up && !dn) begin
                    mY = mY - 1;
                end else if (dn && !up && mY < HOME_Y) begin
                    mY = mY + 1;
                end
                if (mMode == 1 && hitNow) mLatch = 1'b1;
            end
            default: begin
                mLock = mLock - 1;
                if (mLock == 0) mMode = 1;
            end
        endcase
        return score;
    endfunction

    function automatic bit expectedWin(input int v, input bit vw);
        int  d    = (v - mY) & 255;
        bit  show = vw && (d < 16);
`ifdef ROCKET_BLINK_EN
        if (mMode == 2 && (((mLock - 1) >> 2) & 1) == 0) show = 1'b0;
`endif
        return show;
    endfunction

    task automatic windowCheck(input int v, input bit vw);
        bit expWin;
        @(negedge CLK_DRV);
        V        = 8'(v);
        V_WINDOW = vw;
        @(negedge CLK_DRV);
        expWin = expectedWin(v, vw);
        checkOutput("rocket_vwin", ROCKET_VWIN, expWin);
        checkOutput("rocket_row", ROCKET_ROW, expWin ? ((v - mY) & 15) : 0);
    endtask

    // One frame: optional mid-frame hit, some window samples, then the R_RESET tick and its checks.
    task automatic applyStimulus(input bit up, input bit dn, input bit attract,
                                 input bit hitMid, input bit hitAtTick, input int nWin);
        bit score;
        @(negedge CLK_DRV);
        UP_N    = !up;
        DOWN_N  = !dn;
        ATTRACT = attract;
        if (hitMid) begin
            @(negedge CLK_DRV);
            HIT = 1'b1;
            @(negedge CLK_DRV);
            HIT = 1'b0;
            if (mMode == 1) mLatch = 1'b1;
        end
        for (int i = 0; i < nWin; i++) begin
            windowCheck((mY + $urandom_range(0, 40) - 12) & 255, 1'($urandom_range(0, 3) != 0));
        end
        @(negedge CLK_DRV);
        V_WINDOW = 1'b0;
        R_RESET  = 1'b1;
        HIT      = hitAtTick;
        score    = modelTick(up, dn, attract, hitAtTick);
        @(negedge CLK_DRV);
        HIT = 1'b0;
        checkOutput("y_pos", Y_POS, mY);
        checkOutput("stop", STOP, (mY == HOME_Y) ? 1 : 0);
        checkOutput("score_pulse", SCORE_PULSE, score);
        @(negedge CLK_DRV);
        checkOutput("score_pulse_end", SCORE_PULSE, 0);
        checkOutput("y_pos_steady", Y_POS, mY);
        R_RESET = 1'b0;
    endtask

    initial begin
        RESET_N  = 1'b0;
        R_RESET  = 1'b0;
        V_WINDOW = 1'b0;
        V        = 8'd0;
        UP_N     = 1'b1;
        DOWN_N   = 1'b1;
        HIT      = 1'b0;
        ATTRACT  = 1'b1;
        modelReset();
        #12;
        checkOutput("reset_vwin", ROCKET_VWIN, 0);
        checkOutput("reset_row", ROCKET_ROW, 0);
        checkOutput("reset_stop", STOP, 1);
        checkOutput("reset_score", SCORE_PULSE, 0);
        checkOutput("reset_y", Y_POS, HOME_Y);
        @(negedge CLK_DRV);
        RESET_N = 1'b1;

        $display("[TB] start play and sweep the home window");
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int v = 207; v <= 224; v++) windowCheck(v, 1'b1);

        $display("[TB] climb to the top and score");
        for (int i = 0; i < 208; i++) applyStimulus(1, 0, 0, 0, 0, (i % 16 == 0) ? 1 : 0);
        checkOutput("at_top", Y_POS, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);

        $display("[TB] down blocked at home, both buttons hold");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 108; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 1);
        checkOutput("both_hold", Y_POS, 100);

        $display("[TB] mid-frame hit and lockout");
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < HIT_FRAMES; i++) begin
            windowCheck(HOME_Y + 3, 1'b1);
            applyStimulus(1, 0, 0, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("after_lock", Y_POS, 207);

        $display("[TB] hit on the tick cycle, then attract");
        for (int i = 0; i < 157; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);

        $display("[TB] random frames");
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4),
                          1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 14) == 0),
                          1'($urandom_range(0, 29) == 0), 2);
        end

        $display("[TB] asynchronous reset mid-frame");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge CLK_DRV);
        V        = Y_POS;
        V_WINDOW = 1'b1;
        @(posedge CLK_DRV);
        #3;
        RESET_N = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset_y", Y_POS, HOME_Y);
        checkOutput("async_reset_stop", STOP, 1);
        checkOutput("async_reset_vwin", ROCKET_VWIN, 0);
        @(negedge CLK_DRV);
        RESET_N  = 1'b1;
        V_WINDOW = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
